instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 194 +++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Receives a little-endian byte stream from a host over a valid/ready
// handshake, assembles 32-bit instruction words and writes them into
// instruction memory at consecutive word addresses starting at BASE_ADDR.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   When defined, a 32-bit running sum of the written words is kept. After
//   the last word, four more bytes are taken as the expected sum. A mismatch
//   sets err, which holds until the next accepted start or rst. When the
//   macro is undefined, the checksum state and sum logic are absent and err
//   is tied low.
//
// Parameters:
//   ADDRESS_WIDTH  width of mem_addr (byte address)
//   INSTR_WIDTH    instruction word width (only 32 is supported)
//   BASE_ADDR      byte address of the first word written
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle load request, sampled only while idle
//   num_words   word count, latched when start is accepted
//   byte_data   host byte stream
//   byte_valid  byte_data is valid
//   byte_ready  loader accepts a byte this cycle
//   mem_we      instruction-memory write strobe (one cycle per word)
//   mem_addr    byte address of the word being written
//   mem_wdata   assembled instruction word
//   busy        high while a load is in progress (not IDLE, not DONE)
//   done        one-cycle pulse when a load completes
//   err         checksum mismatch flag
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              num_words,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [INSTR_WIDTH-1:0]   mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM  = 3'd3;
`endif
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [15:0] num_words_q;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  // Bytes 0..2 of the word in flight; byte 3 goes straight into the output.
  logic [23:0] partial;
  logic        accept;
  logic        last_word;

  assign accept    = byte_valid && byte_ready;
  assign last_word = (word_idx + 16'd1) == num_words_q;

  // Outputs decoded from state so mem_we lines up with the WRITE cycle.
  assign mem_we = (state == WRITE);
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);
`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state == LOAD) || (state == CSUM);
`else
  assign byte_ready = (state == LOAD);
`endif

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = (num_words == 16'd0) ? DONE : LOAD;
      end
      LOAD: begin
        if (accept && byte_idx == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = CSUM;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept && byte_idx == 2'd3) next_state = DONE;
      end
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      num_words_q <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      partial     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            num_words_q <= num_words;
            word_idx    <= '0;
            byte_idx    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum         <= '0;
            err_q       <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: partial[7:0]   <= byte_data;
              2'd1: partial[15:8]  <= byte_data;
              2'd2: partial[23:16] <= byte_data;
              default: begin
                // Final byte: present the word and its address for WRITE.
                mem_wdata <= INSTR_WIDTH'({byte_data, partial});
                mem_addr  <= BASE_ADDR + (ADDRESS_WIDTH'(word_idx) << 2);
              end
            endcase
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum      <= sum + 32'(mem_wdata);
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: partial[7:0]   <= byte_data;
              2'd1: partial[15:8]  <= byte_data;
              2'd2: partial[23:16] <= byte_data;
              default: err_q <= ({byte_data, partial} != sum);
            endcase
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
`timescale 1ns/1ps
module tb_instr_mem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_words;
  logic [7:0]  byte_data;
  logic        byte_valid;

  logic        ready_a, we_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, wdata_a;
  logic        ready_b, we_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, wdata_b;

  always #5 clk = ~clk;

  // Two loaders on the same stream: base 0 and base 0x100.
  instr_mem_loader #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  instr_mem_loader #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .BASE_ADDR(32'h100)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];
  int done_cnt  = 0;
  int bad_ready = 0;
  int cyc_n     = 0;
  int last_we   = 0;
  int done_cyc  = 0;

  always @(negedge clk) begin
    cyc_n++;
    if (we_a) begin
      wq_a.push_back({addr_a, wdata_a});
      last_we = cyc_n;
    end
    if (we_b) wq_b.push_back({addr_b, wdata_b});
    if (done_a) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if ((we_a && ready_a) || (we_b && ready_b)) bad_ready++;
  end

  task automatic clear_monitor();
    wq_a.delete();
    wq_b.delete();
    done_cnt  = 0;
    bad_ready = 0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int               n;
    logic [3:0][31:0] w;
    bit               bad_csum;
    int               stall;     // 0 none, 1 toggle every cycle, 2 random
    bit               inject;    // pulse start while busy
    int               exp_writes;
    bit               exp_err;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input bit bad, input int stall, input bit inj);
    vec_t v;
    v.n          = n;
    v.w[0]       = w0;
    v.w[1]       = w1;
    v.w[2]       = w2;
    v.w[3]       = w3;
    v.bad_csum   = bad;
    v.stall      = stall;
    v.inject     = inj;
    v.exp_writes = n;
    v.exp_err    = CK && bad && (n > 0);
    return v;
  endfunction

  // Drive one complete load and compare against the reference model:
  // word i lands at base + 4*i, data is the little-endian assembly of its bytes.
  task automatic run_load(input vec_t v, input string tag);
    logic [7:0]  bytes[$];
    logic [31:0] sum;
    logic [31:0] csum;
    int idx;
    int cyc;
    clear_monitor();
    sum = 32'd0;
    for (int i = 0; i < v.n; i++) begin
      for (int k = 0; k < 4; k++) bytes.push_back(v.w[i][8*k +: 8]);
      sum = sum + v.w[i];
    end
    csum = v.bad_csum ? sum + 32'd1 : sum;
    if (CK && v.n > 0)
      for (int k = 0; k < 4; k++) bytes.push_back(csum[8*k +: 8]);

    @(posedge clk); #1;
    num_words = 16'(v.n);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    num_words = 16'd9;  // must not matter after acceptance
    idx = 0;
    cyc = 0;
    while (idx < bytes.size() && cyc < 400) begin
      start = v.inject && (cyc == 2);
      case (v.stall)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (cyc % 2 == 0);
        default: byte_valid = ($urandom_range(0, 3) != 0);
      endcase
      byte_data = bytes[idx];
      @(negedge clk);
      if (byte_valid && ready_a) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check({tag, "_bytes_fed"}, 64'(idx), 64'(bytes.size()));

    for (int k = 0; k < 40 && done_cnt == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy_a), 64'd0);
    check({tag, "_err"}, 64'(err_a), 64'(v.exp_err));
    check({tag, "_ready_in_write"}, 64'(bad_ready), 64'd0);
    check({tag, "_nwrites_a"}, 64'(wq_a.size()), 64'(v.exp_writes));
    check({tag, "_nwrites_b"}, 64'(wq_b.size()), 64'(v.exp_writes));
    for (int i = 0; i < v.n && i < wq_a.size() && i < wq_b.size(); i++) begin
      check($sformatf("%s_w%0d_a", tag, i), wq_a[i], {32'h0 + 32'(4 * i), v.w[i]});
      check($sformatf("%s_w%0d_b", tag, i), wq_b[i], {32'h100 + 32'(4 * i), v.w[i]});
    end
`ifndef LOADER_CHECKSUM_EN
    if (v.n > 0) check({tag, "_done_latency"}, 64'(done_cyc - last_we), 64'd1);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = mk(1, 32'h00000513, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    vecs[1] = mk(3, 32'h00000513, 32'h00100593, 32'h00B50633, 32'h0, 1'b0, 0, 1'b0);
    vecs[2] = mk(2, 32'hDEADBEEF, 32'h01234567, 32'h0, 32'h0, 1'b0, 1, 1'b0);
    vecs[3] = mk(2, 32'h00000001, 32'h00000002, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    vecs[4] = mk(2, 32'h00000001, 32'h00000002, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    vecs[5] = mk(1, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1);

    rst        = 1'b1;
    start      = 1'b0;
    num_words  = 16'd0;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready_a), 64'd0);
    check("rst_we", 64'(we_a), 64'd0);
    check("rst_addr_b", 64'(addr_b), 64'd0);
    check("rst_wdata", 64'(wdata_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle: bytes offered are not consumed.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_ready", 64'(ready_a), 64'd0);
    check("idle_busy", 64'(busy_a), 64'd0);
    @(posedge clk); #1;
    byte_valid = 1'b0;

    // Table-driven loads.
    for (int i = 0; i < 6; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Zero-word load: DONE on the cycle after acceptance, no write.
    clear_monitor();
    @(posedge clk); #1;
    num_words = 16'd0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 64'(done_a), 64'd1);
    check("zero_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    check("zero_done_drop", 64'(done_a), 64'd0);
    check("zero_no_write", 64'(wq_a.size()), 64'd0);

    // Reset in the middle of word 0, then a fresh 1-word load.
    clear_monitor();
    @(posedge clk); #1;
    num_words = 16'd1;
    start     = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    @(posedge clk); #1;
    byte_data = 8'hBB;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_addr", 64'(addr_b), 64'd0);
    check("midrst_wdata", 64'(wdata_a), 64'd0);
    check("midrst_ready", 64'(ready_a), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_no_write", 64'(wq_a.size()), 64'd0);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    run_load(mk(1, 32'h11223344, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0), "after_rst");

    // Randomized loads.
    for (int r = 0; r < 16; r++) begin
      vec_t v;
      v = mk($urandom_range(0, 4), $urandom, $urandom, $urandom, $urandom,
             bit'($urandom_range(0, 1)), $urandom_range(0, 2), bit'($urandom_range(0, 1)));
      run_load(v, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
